// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the MMIO interval timer: register map, CTRL/STATUS
// bit positions, FSM encoding and reset constants.
package mmio_timer_pkg;

  localparam logic [2:0] REG_CNT_LO   = 3'd0;
  localparam logic [2:0] REG_CNT_HI   = 3'd1;
  localparam logic [2:0] REG_LATCH_LO = 3'd2;
  localparam logic [2:0] REG_LATCH_HI = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_ID       = 3'd7;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_NMI_SEL = 3;

  localparam int STAT_IFLAG   = 0;
  localparam int STAT_RUNNING = 1;

  localparam logic [15:0] LATCH_RST    = 16'hFFFF;
  localparam logic [7:0]  PRESCALE_RST = 8'h00;
  localparam logic [3:0]  CTRL_RST     = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_t;

  // One-hot per-offset strobes for the current bus cycle plus the write byte.
  typedef struct packed {
    logic [7:0] wr;
    logic [7:0] rd;
    logic [7:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mmio_timer_if.sv
// CPU-side MMIO bus. dataio is resolved here: the responder drives it through
// rdata/oe and the bus master through wdata/wen.
interface mmio_timer_if;
  logic [7:0] abh;
  logic [7:0] abl;
  logic       rw;
  wire  [7:0] dataio;
  logic [7:0] rdata;
  logic       oe;
  logic [7:0] wdata;
  logic       wen;
  logic       hit;
  logic       irq;
  logic       nmi;

  assign dataio = oe  ? rdata : 8'hzz;
  assign dataio = wen ? wdata : 8'hzz;

  modport slave  (input  abh, abl, rw, dataio,
                  output rdata, oe, hit, irq, nmi);
  modport master (output abh, abl, rw, wdata, wen,
                  input  dataio, hit, irq, nmi);
endinterface

// File: rtl/mmio_timer_bus_responder_if.sv
// Generic 8-register MMIO responder: window decode, combinational read mux,
// tri-state enable and per-offset read/write strobes.
module bus_responder_if
  import mmio_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD000
) (
  mmio_timer_if.slave     bus,
  input  logic [7:0][7:0] regs_rd,
  output bus_req_t        req
);

  logic [2:0] off;

  assign off       = bus.abl[2:0];
  assign bus.hit   = (bus.abh == BASE_ADDR[15:8]) && (bus.abl[7:3] == BASE_ADDR[7:3]);
  assign bus.oe    = bus.hit & bus.rw;
  assign bus.rdata = regs_rd[off];

  always_comb begin
    req       = '0;
    req.wdata = bus.dataio;
    if (bus.hit) begin
      if (bus.rw) req.rd[off] = 1'b1;
      else        req.wr[off] = 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// 16-bit prescaled down-counter with one-shot/continuous modes, raising irq
// (level) or nmi (one-clock pulse) on underflow.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter logic [7:0]  ID_VALUE  = 8'h65
) (
  input  logic        clk,
  input  logic        clr,
  mmio_timer_if.slave bus
);

  tmr_state_t      state, state_n;
  logic [15:0]     counter, counter_n, latch;
  logic [7:0]      prescale, pre_cnt, pre_cnt_n, snap_hi;
  logic [3:0]      ctrl, ctrl_n;
  logic            iflag, iflag_n, iflag_d;
  logic            irq_q, nmi_q;
  logic            underflow, wr_lhi;
  bus_req_t        req;
  logic [7:0][7:0] regs_rd;
  logic            unused_ok;

  bus_responder_if #(.BASE_ADDR(BASE_ADDR)) u_resp (
    .bus     (bus),
    .regs_rd (regs_rd),
    .req     (req)
  );

  assign unused_ok = ^{req.rd[7:1], req.wr[REG_CNT_LO], req.wr[REG_CNT_HI], req.wr[REG_ID]};

  always_comb begin
    regs_rd               = '0;
    regs_rd[REG_CNT_LO]   = counter[7:0];
    regs_rd[REG_CNT_HI]   = snap_hi;
    regs_rd[REG_LATCH_LO] = latch[7:0];
    regs_rd[REG_LATCH_HI] = latch[15:8];
    regs_rd[REG_CTRL]     = {4'b0, ctrl};
    regs_rd[REG_STATUS]   = {6'b0, state == ST_RUN, iflag};
    regs_rd[REG_PRESCALE] = prescale;
    regs_rd[REG_ID]       = ID_VALUE;
  end

  assign wr_lhi = req.wr[REG_LATCH_HI];
  assign ctrl_n = req.wr[REG_CTRL] ? req.wdata[3:0] : ctrl;

  always_comb begin
    state_n   = state;
    counter_n = counter;
    pre_cnt_n = pre_cnt;
    underflow = 1'b0;
    case (state)
      ST_IDLE: if (ctrl[CTRL_ENABLE]) state_n = ST_RUN;
      ST_RUN: begin
        if (!ctrl[CTRL_ENABLE]) begin
          state_n = ST_IDLE;
        end else if (pre_cnt != 8'd0) begin
          pre_cnt_n = pre_cnt - 8'd1;
        end else begin
          pre_cnt_n = prescale;
          if (counter != 16'd0) begin
            counter_n = counter - 16'd1;
          end else begin
            underflow = 1'b1;
            if (ctrl[CTRL_CONT]) counter_n = latch;
            else                 state_n   = ST_DONE;
          end
        end
      end
      ST_DONE: ;
      default: state_n = ST_IDLE;
    endcase
    // A LATCH_HI write overrides whatever the counter would have done this edge.
    if (wr_lhi) begin
      counter_n = {req.wdata, latch[7:0]};
      pre_cnt_n = prescale;
      state_n   = ctrl[CTRL_ENABLE] ? ST_RUN : ST_IDLE;
      underflow = 1'b0;
    end
  end

  always_comb begin
    iflag_n = iflag;
    if (wr_lhi)                                        iflag_n = 1'b0;
    else if (underflow)                                iflag_n = 1'b1;
    else if (req.wr[REG_STATUS] && req.wdata[STAT_IFLAG]) iflag_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      counter  <= 16'd0;
      latch    <= LATCH_RST;
      ctrl     <= CTRL_RST;
      prescale <= PRESCALE_RST;
      pre_cnt  <= 8'd0;
      snap_hi  <= 8'd0;
      iflag    <= 1'b0;
      iflag_d  <= 1'b0;
      irq_q    <= 1'b0;
      nmi_q    <= 1'b0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      pre_cnt <= pre_cnt_n;
      iflag   <= iflag_n;
      iflag_d <= iflag;
      ctrl    <= ctrl_n;
      if (req.wr[REG_LATCH_LO]) latch[7:0]  <= req.wdata;
      if (wr_lhi)               latch[15:8] <= req.wdata;
      if (req.wr[REG_PRESCALE]) prescale    <= req.wdata;
      if (req.rd[REG_CNT_LO])   snap_hi     <= counter[15:8];
      irq_q <= iflag_n & ctrl_n[CTRL_IRQ_EN] & ~ctrl_n[CTRL_NMI_SEL];
      // nmi follows the registered IFLAG rise by one edge, so it fires once per set.
      nmi_q <= iflag & ~iflag_d & ctrl[CTRL_IRQ_EN] & ctrl[CTRL_NMI_SEL];
    end
  end

  assign bus.irq = irq_q;
  assign bus.nmi = nmi_q;

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped 16-bit interval timer that sits on the CPU side address/data bus beside `ram` and acts as a bus responder. It decodes the CPU's `{abh,abl}` / `rw` / `dataio` cycles, supports a prescaled down-counter in one-shot or continuous mode, and raises `irq` or `nmi` toward the CPU core on underflow.

## Interface
Parameters:
- BASE_ADDR, 16'hD000, base of the 8-byte register window; the low 3 bits must be 0.
- ID_VALUE, 8'h65, constant returned by the ID register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- abh  in  8  address bus high, driven by the CPU.
- abl  in  8  address bus low.
- rw  in  1  1 = CPU read, 0 = CPU write.
- dataio  inout  8  shared data bus. Driven only when `hit & rw`, otherwise high-Z.
- hit  out  1  combinational; `abh==BASE[15:8] && abl[7:3]==BASE[7:3]`. The board uses it to gate `ram`.
- irq  out  1  level interrupt request, active-high.
- nmi  out  1  single-clock pulse, active-high.

## Operation
Register map (offset = `abl[2:0]`):
- 0 CNT_LO (R): counter[7:0]. A read also latches counter[15:8] into `snap_hi`.
- 1 CNT_HI (R): `snap_hi`.
- 2 LATCH_LO (R/W).
- 3 LATCH_HI (R/W): a write loads counter ← {new LATCH_HI, LATCH_LO}, prescaler ← PRESCALE and clears IFLAG. The state becomes RUN if ENABLE=1, else IDLE.
- 4 CTRL (R/W): bit0 ENABLE, bit1 CONT (reload on underflow), bit2 IRQ_EN, bit3 NMI_SEL. Bits 7:4 read 0.
- 5 STATUS: bit0 IFLAG (write 1 to clear), bit1 RUNNING (R only, =state==RUN). Other bits read 0.
- 6 PRESCALE (R/W): the counter ticks once per PRESCALE+1 clocks.
- 7 ID (R): ID_VALUE. Writes are ignored.

Side effects:
- Writes and read side effects take effect on the clk edge where `hit` holds.
- One bus cycle is one clock, so a read held N clocks re-snapshots N times.

State machine:
- IDLE: counter frozen. ENABLE 0→1 → RUN, resuming from the current count.
- RUN: each edge, if prescaler==0 then prescaler ← PRESCALE and tick, else prescaler−1. On a tick, counter!=0 gives counter−1; counter==0 is an underflow.
  - Underflow sets IFLAG.
  - If CONT: counter ← latch and stay in RUN.
  - Else: go to DONE with counter held at 0.
  - ENABLE cleared → IDLE.
- DONE: ENABLE changes have no effect. Only a LATCH_HI write leaves DONE.

Outputs:
- irq = IFLAG & IRQ_EN & ~NMI_SEL, registered.
- nmi pulses for 1 clock on the edge after IFLAG goes 0→1, when IRQ_EN & NMI_SEL are both 1. There is no repeat while IFLAG stays set.

Priorities on the same edge:
- An underflow wins over a STATUS clear: IFLAG stays 1.
- A LATCH_HI write wins over an underflow: reload from the new latch, IFLAG cleared, no nmi.
- A CTRL write takes effect for the next edge.

Reset values:
- Counter 0, latch 16'hFFFF, CTRL 0, PRESCALE 0, IFLAG 0, snap_hi 0, state IDLE.
- irq 0, nmi 0, dataio high-Z.
- clr mid-RUN wins over everything and resets all of the above on that edge.

## Timing
- Read data is combinational from the address: valid in the same cycle `hit & rw` is presented, with no wait states. This matches `ram`.
- Underflow occurs (N+1)·(P+1) edges after the LATCH_HI write edge, with N = latch and P = PRESCALE.
- IFLAG sets on that edge; irq rises on the same edge; nmi is high for the following cycle.
- Continuous period: (N+1)·(P+1) clocks between IFLAG set events.
- Widths:
  - Counter and latch are 16-bit unsigned; reload wraps 0 → N.
  - Latch 0 gives an underflow every P+1 clocks.
  - Prescaler is 8-bit.

## Structure
- The shared package holds:
  - register offsets REG_CNT_LO..REG_ID;
  - CTRL bit indices;
  - the state encoding IDLE/RUN/DONE;
  - reset constants (LATCH_RST = 16'hFFFF).
- One sub-module, `bus_responder_if`: address decode (`hit`), read mux, tri-state `dataio` drive and per-register write strobes. It is reusable by later MMIO peripherals.
- Counter, prescaler, FSM and interrupt logic live in `mmio_timer`.

## Test plan
- Reset: pulse clr, read BASE+7 → 0x65, BASE+4 → 0x00, {LATCH_HI,LATCH_LO} = 0xFFFF. irq=nmi=0, and dataio is Z when hit=0.
- One-shot: PRESCALE=0, CTRL=0x05, LATCH_LO=0x03, LATCH_HI=0x00.
  - irq rises 4 edges after the LATCH_HI write; STATUS reads 0x01; CNT_LO stays 0x00.
  - Write STATUS=0x01 → irq low next edge and no restart.
- Continuous: PRESCALE=1, CTRL=0x07, latch 0x0002 → IFLAG sets every 6 clocks. Clear it between events; RUNNING stays 1.
- NMI route: CTRL=0x0D, latch 0x0000, PRESCALE=0 → exactly one 1-clock nmi pulse, irq stays 0.
- Snapshot: latch 0x0100, PRESCALE=0, CTRL=0x01; read CNT_LO when it shows 0x00 → CNT_HI read later returns 0x01 although the counter is now 0x00FF.
- Collisions: a STATUS clear write on the underflow edge leaves IFLAG=1. A LATCH_HI write on the underflow edge gives IFLAG=0 and the new count. clr asserted mid-RUN gives all reset values on that edge.
